btn_debounce: RTL

//  Front-end conditioning for raw board push-buttons. Synchronises each button into clk,

---
 rtl/btn_debounce_if.sv | 11 +
 rtl/btn_debounce.sv | 93 +++++++++
 2 files changed

// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pad side and the debounced level consumer.
interface btn_debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] db_busy;

  modport master (output btn_raw, input btn_db, input db_busy);
  modport slave  (input btn_raw, output btn_db, output db_busy);
endinterface

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF sync plus per-button stability counter; optional BTN_DB_AUTOREPEAT_EN.
// Latency DB_CYCLES+2 edges from a stable raw level; no backpressure (free-running levels).
module btn_debounce #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000
) (
  input logic           clk,
  input logic           rst_n,
  btn_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync2[i] != filt[i]) && (cnt == DB_LAST);

    // Any edge where the synchronised level agrees with the output restarts filtering.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        filt[i] <= 1'b0;
      end else if (sync2[i] == filt[i]) begin
        cnt <= '0;
      end else if (accept) begin
        filt[i] <= sync2[i];
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign bus.db_busy[i] = (cnt != '0);

`ifdef BTN_DB_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PER - 1);

    logic [CNT_W-1:0] rcnt;
    logic             per_phase;
    logic             mask;
    logic             release_acc;
    logic [CNT_W-1:0] rpt_last;

    assign release_acc = filt[i] && accept;
    assign rpt_last    = per_phase ? RPT_PER_LAST : RPT_DLY_LAST;

    // mask only blanks the output; filt and cnt keep running underneath it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt      <= '0;
        per_phase <= 1'b0;
        mask      <= 1'b0;
      end else if (!filt[i] || release_acc) begin
        rcnt      <= '0;
        per_phase <= 1'b0;
        mask      <= 1'b0;
      end else if (rcnt == rpt_last) begin
        rcnt      <= '0;
        per_phase <= 1'b1;
        mask      <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
        mask <= 1'b0;
      end
    end

    assign bus.btn_db[i] = filt[i] & ~mask;
`else
    assign bus.btn_db[i] = filt[i];
`endif
  end

endmodule
